// File: rtl/hive_alu_cond_if.sv
// Bus bundle between the issue/ALU side and the hive_alu_cond condition evaluator.
interface hive_alu_cond_if #(
    parameter int unsigned ALU_W = 32,
    parameter int unsigned FLG_W = 4
);
    logic             vld_i;
    logic [3:0]       cnd_i;
    logic [ALU_W-1:0] res_i;
    logic [FLG_W-1:0] flg_i;
    logic             clr_i;
    logic             vld_o;
    logic             tkn_o;
    logic [ALU_W-1:0] res_o;
    logic [1:0]       stk_o;

    modport master (
        output vld_i, cnd_i, res_i, flg_i, clr_i,
        input  vld_o, tkn_o, res_o, stk_o
    );

    modport slave (
        input  vld_i, cnd_i, res_i, flg_i, clr_i,
        output vld_o, tkn_o, res_o, stk_o
    );
endinterface

// File: rtl/hive_alu_cond.sv
// Condition evaluator aligned to the add/sub pipeline; registers a taken decision per op.
// Optional sticky {ovf, cry} status is built only when HIVE_ALU_COND_STICKY_EN is defined.
module hive_alu_cond #(
    parameter int unsigned ALU_W = 32,
    parameter int unsigned FLG_W = 4,
    parameter int unsigned LAT   = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    hive_alu_cond_if.slave bus
);
    logic [LAT-1:0]      dl_vld_q, dl_vld_d;
    logic [LAT-1:0][3:0] dl_cnd_q, dl_cnd_d;
    logic                vld_q, vld_d;
    logic                tkn_q, tkn_d;
    logic [ALU_W-1:0]    res_q, res_d;
    logic                al_vld;
    logic [3:0]          al_cnd;
    logic                z, n, c, v, cond;

    always_comb begin
        dl_vld_d    = dl_vld_q;
        dl_cnd_d    = dl_cnd_q;
        dl_vld_d[0] = bus.vld_i;
        dl_cnd_d[0] = bus.cnd_i;
        for (int unsigned i = 1; i < LAT; i++) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_cnd_d[i] = dl_cnd_q[i-1];
        end
    end

    assign al_vld = dl_vld_q[LAT-1];
    assign al_cnd = dl_cnd_q[LAT-1];

    // v: bits 32 and 31 of the extended result disagree, so the 32-bit result is not representative
    assign z = (bus.res_i == '0);
    assign n = bus.flg_i[3];
    assign c = bus.flg_i[2];
    assign v = bus.flg_i[1] ^ bus.flg_i[0];

    always_comb begin
        cond = 1'b0;
        case (al_cnd)
            4'd0:    cond = 1'b0;
            4'd1:    cond = 1'b1;
            4'd2:    cond = z;
            4'd3:    cond = !z;
            4'd4:    cond = n;
            4'd5:    cond = !n;
            4'd6:    cond = n | z;
            4'd7:    cond = !n & !z;
            4'd8:    cond = c;
            4'd9:    cond = !c;
            4'd10:   cond = v;
            4'd11:   cond = !v;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        vld_d = al_vld;
        tkn_d = al_vld & cond;
        res_d = bus.res_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dl_vld_q <= '0;
            dl_cnd_q <= '0;
            vld_q    <= 1'b0;
            tkn_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            dl_vld_q <= dl_vld_d;
            dl_cnd_q <= dl_cnd_d;
            vld_q    <= vld_d;
            tkn_q    <= tkn_d;
            res_q    <= res_d;
        end
    end

    assign bus.vld_o = vld_q;
    assign bus.tkn_o = tkn_q;
    assign bus.res_o = res_q;

`ifdef HIVE_ALU_COND_STICKY_EN
    logic [1:0] stk_q, stk_d;

    // Clear first, then OR in the aligned op so a same-cycle set survives the clear
    always_comb begin
        stk_d = bus.clr_i ? 2'b00 : stk_q;
        if (al_vld) begin
            stk_d = stk_d | {v, c};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stk_q <= '0;
        end else begin
            stk_q <= stk_d;
        end
    end

    assign bus.stk_o = stk_q;
`else
    assign bus.stk_o = '0;
`endif
endmodule

// File: tb/tb_hive_alu_cond.sv
// Scoreboard bench for hive_alu_cond: models the add/sub unit feeding it and checks every cycle.
module tb_hive_alu_cond;
    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sgn;
        logic [3:0]  cnd;
        logic        vld;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic        tkn;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hive_alu_cond_if #(.ALU_W(32), .FLG_W(4)) bus ();

    hive_alu_cond #(.ALU_W(32), .FLG_W(4), .LAT(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    op_t         hist[$];
    exp_t        sb[$];
    logic [1:0]  stk_m  = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", tag, cyc, obs, exp);
        end
    endtask

    // 34-bit extended add/sub as the upstream unit computes it
    function automatic logic [33:0] alu(input op_t op);
        logic [33:0] ea, eb;
        ea = op.sgn ? {{2{op.a[31]}}, op.a} : {2'b00, op.a};
        eb = op.sgn ? {{2{op.b[31]}}, op.b} : {2'b00, op.b};
        return op.sub ? (ea - eb) : (ea + eb);
    endfunction

    function automatic logic taken(input logic [3:0] cnd, input logic [33:0] e);
        logic zr, lt, cy, ov;
        zr = (e[31:0] == 32'd0);
        lt = e[33];
        cy = e[32];
        ov = (e[32] != e[31]);
        case (cnd)
            4'd0:  return 1'b0;
            4'd1:  return 1'b1;
            4'd2:  return zr;
            4'd3:  return !zr;
            4'd4:  return lt;
            4'd5:  return !lt;
            4'd6:  return lt || zr;
            4'd7:  return !(lt || zr);
            4'd8:  return cy;
            4'd9:  return !cy;
            4'd10: return ov;
            4'd11: return !ov;
            default: return 1'b0;
        endcase
    endfunction

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               input logic sgn, input logic [3:0] cnd, input logic vld);
        op_t o;
        o.a = a; o.b = b; o.sub = sub; o.sgn = sgn; o.cnd = cnd; o.vld = vld;
        return o;
    endfunction

    function automatic op_t idle();
        return mk($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)), 1'b0);
    endfunction

    task automatic step(input op_t op, input logic clr, input logic r);
        op_t         al;
        logic [33:0] e;
        logic [31:0] exp_res;
        logic        exp_v;
        exp_t        x;

        al = hist.pop_front();
        e  = alu(al);
        rst        = r;
        bus.vld_i  = op.vld;
        bus.cnd_i  = op.cnd;
        bus.clr_i  = clr;
        bus.res_i  = e[31:0];
        bus.flg_i  = {e[33], e[32], e[32], e[31]};
        exp_res    = r ? 32'd0 : e[31:0];

        if (r) begin
            hist.delete();
            for (int i = 0; i < int'(LAT); i++) hist.push_back(idle());
            sb.delete();
        end else begin
            hist.push_back(op);
            if (op.vld) begin
                x.res = alu(op);
                x.tkn = taken(op.cnd, alu(op));
                x.due = cyc + LAT + 1;
                sb.push_back(x);
            end
        end

`ifdef HIVE_ALU_COND_STICKY_EN
        if (r) begin
            stk_m = 2'b00;
        end else begin
            if (clr) stk_m = 2'b00;
            if (al.vld) stk_m = stk_m | {e[32] ^ e[31], e[32]};
        end
`endif

        @(posedge clk);
        cyc++;
        #1;
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        chk("vld_o", 32'(bus.vld_o), 32'(exp_v));
        chk("res_o", bus.res_o, exp_res);
        chk("stk_o", 32'(bus.stk_o), 32'(stk_m));
        if (exp_v) begin
            x = sb.pop_front();
            chk("tkn_o", 32'(bus.tkn_o), 32'(x.tkn));
            chk("sb_res", bus.res_o, x.res);
        end else begin
            chk("tkn_idle", 32'(bus.tkn_o), 32'd0);
        end
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(idle(), 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < int'(LAT); i++) hist.push_back(idle());
        bus.vld_i = 1'b0;
        bus.cnd_i = '0;
        bus.res_i = '0;
        bus.flg_i = '0;
        bus.clr_i = 1'b0;

        step(idle(), 1'b0, 1'b1);
        step(idle(), 1'b0, 1'b1);
        idles(2);

        // unsigned wrap to zero: carry and zero conditions
        step(mk(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd8, 1'b1), 1'b0, 1'b0);
        idles(LAT + 1);
        step(mk(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd2, 1'b1), 1'b0, 1'b0);
        idles(LAT + 1);

        // signed compare and overflow
        step(mk(32'd5, 32'd7, 1'b1, 1'b1, 4'd4, 1'b1), 1'b0, 1'b0);
        step(mk(32'd5, 32'd7, 1'b1, 1'b1, 4'd5, 1'b1), 1'b0, 1'b0);
        step(mk(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 4'd10, 1'b1), 1'b0, 1'b0);
        idles(LAT + 1);

        // back-to-back issue over all codes, including some zero results
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            a = $urandom;
            step(mk(a, (i % 3 == 0) ? a : 32'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    4'(i), 1'b1), 1'b0, 1'b0);
        end
        idles(LAT + 1);

        // reset with two ops in flight, then a fresh issue
        step(mk(32'd1, 32'd1, 1'b0, 1'b0, 4'd1, 1'b1), 1'b0, 1'b0);
        step(mk(32'd2, 32'd1, 1'b0, 1'b0, 4'd1, 1'b1), 1'b0, 1'b0);
        step(idle(), 1'b0, 1'b1);
        step(mk(32'd9, 32'd3, 1'b1, 1'b0, 4'd1, 1'b1), 1'b0, 1'b0);
        idles(LAT + 2);

        // sticky: overflow, then carry arriving with a same-cycle clear, then a lone clear
        step(mk(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 4'd10, 1'b1), 1'b0, 1'b0);
        idles(LAT + 1);
        step(mk(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd8, 1'b1), 1'b0, 1'b0);
        idles(LAT - 1);
        step(idle(), 1'b1, 1'b0);
        idles(2);
        step(idle(), 1'b1, 1'b0);
        idles(2);

        for (int i = 0; i < int'(LAT) + 4 && sb.size() > 0; i++) step(idle(), 1'b0, 1'b0);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
